// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, access sizes and the lane-enable helper.
// Imported by the bus master and its lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] be_of(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Request/grant/response data-memory bus between the LSU and memory.
// The master drives the request side; the slave answers.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: enables and replicated store data on the way out,
// byte/half extraction with sign or zero extension on the way back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rext
);

  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    be = be_of(size, lo);
    rb = rdata[{lo, 3'b000} +: 8];
    rh = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        wdata = {4{wd[7:0]}};
        rext  = uns ? {24'b0, rb} : {{24{rb[7]}}, rb};
      end
      SZ_H: begin
        wdata = {2{wd[15:0]}};
        rext  = uns ? {16'b0, rh} : {{16{rh[15]}}, rh};
      end
      default: begin
        wdata = wd;
        rext  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Data-memory bus initiator: stalls the core across a multi-cycle access
// and returns the extended load result with a one-cycle done pulse.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_enb,
  input  logic              lb,
  input  logic              lh,
  input  logic              lw,
  input  logic              lbu,
  input  logic              lhu,
  input  logic              sb,
  input  logic              sh,
  input  logic              sw,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic              err,
  lsu_bus_master_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, nxt;
  logic              op_vld, op_we, op_uns;
  logic [1:0]        op_sz;
  logic              mis, go, tmo, hit, busy;
  logic [1:0]        al_sz, al_lo, sz_q, lo_q;
  logic              al_uns, uns_q, we_q, err_q;
  logic [3:0]        al_be, be_q;
  logic [31:0]       al_wdata, wdata_q, rdata_q, rext;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     cnt;

  // Stores outrank loads; within each class wider accesses win.
  always_comb begin
    op_vld = 1'b1;
    op_we  = 1'b0;
    op_sz  = SZ_W;
    op_uns = 1'b0;
    priority case (1'b1)
      sw: op_we = 1'b1;
      sh: begin op_we = 1'b1; op_sz = SZ_H; end
      sb: begin op_we = 1'b1; op_sz = SZ_B; end
      load_enb && lw:  op_sz = SZ_W;
      load_enb && lh:  op_sz = SZ_H;
      load_enb && lhu: begin op_sz = SZ_H; op_uns = 1'b1; end
      load_enb && lb:  op_sz = SZ_B;
      load_enb && lbu: begin op_sz = SZ_B; op_uns = 1'b1; end
      default: op_vld = 1'b0;
    endcase
  end

  assign mis = (op_sz == SZ_H && address[0]) ||
               (op_sz == SZ_W && address[1:0] != 2'b00);
  assign go   = rst_n && state == IDLE && op_vld && !mis;
  assign busy = state == REQ || state == WAIT;
  assign tmo  = cnt >= CW'(TIMEOUT_CYCLES - 1);
  assign hit  = (state == REQ && bus.gnt && bus.rvalid) ||
                (state == WAIT && bus.rvalid);

  assign misaligned = state == IDLE && op_vld && mis;

  assign al_sz  = state == IDLE ? op_sz : sz_q;
  assign al_uns = state == IDLE ? op_uns : uns_q;
  assign al_lo  = state == IDLE ? address[1:0] : lo_q;

  lsu_lane_align u_align (
    .size  (al_sz),
    .uns   (al_uns),
    .lo    (al_lo),
    .wd    (write_data),
    .rdata (rdata_q),
    .be    (al_be),
    .wdata (al_wdata),
    .rext  (rext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (go) nxt = REQ;
      REQ: begin
        if (bus.gnt && bus.rvalid) nxt = DONE;
        else if (bus.gnt)          nxt = WAIT;
        else if (tmo)              nxt = DONE;
      end
      WAIT:    if (bus.rvalid || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    read_data = '0;
    bus.req   = 1'b0;
    unique case (state)
      IDLE: stall = go;
      REQ: begin
        stall   = 1'b1;
        bus.req = 1'b1;
      end
      WAIT: stall = 1'b1;
      DONE: begin
        done = 1'b1;
        err  = err_q;
        if (!err_q && !we_q) read_data = rext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sz_q    <= SZ_W;
      uns_q   <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else if (busy)     cnt <= cnt + 1'b1;
      if (go) begin
        addr_q  <= {address[ADDR_W-1:2], 2'b00};
        we_q    <= op_we;
        be_q    <= al_be;
        wdata_q <= al_wdata;
        sz_q    <= op_sz;
        uns_q   <= op_uns;
        lo_q    <= address[1:0];
        err_q   <= 1'b0;
      end
      // A real response always overrides a timeout flagged earlier.
      if (hit) begin
        rdata_q <= bus.rdata;
        err_q   <= bus.err;
      end else if (busy && tmo) begin
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized and directed checks of lsu_bus_master against a
// behavioural model of sizes, lanes, extension and latency.
module tb_lsu_bus_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_enb, lb, lh, lw, lbu, lhu, sb, sh, sw;
  logic [31:0] address, write_data, read_data;
  logic        stall, done, misaligned, err;

  lsu_bus_master_if bus ();

  lsu_bus_master #(
    .TIMEOUT_CYCLES(TMO),
    .ADDR_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_enb(load_enb),
    .lb(lb), .lh(lh), .lw(lw), .lbu(lbu), .lhu(lhu),
    .sb(sb), .sh(sh), .sw(sw),
    .address(address), .write_data(write_data),
    .read_data(read_data), .stall(stall), .done(done),
    .misaligned(misaligned), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          o_done_cyc, o_stall_n, o_req_n;
  logic        o_unstable, o_we, o_err;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rd;

  // kinds: 0 lb,1 lh,2 lw,3 lbu,4 lhu,5 sb,6 sh,7 sw
  function automatic int first_kind(input logic [7:0] m);
    int pri[8];
    pri = '{7, 6, 5, 2, 1, 4, 0, 3};
    for (int i = 0; i < 8; i++) if (m[pri[i]]) return pri[i];
    return -1;
  endfunction

  function automatic int size_of(input int k);
    if (k == 0 || k == 3 || k == 5) return 1;
    if (k == 1 || k == 4 || k == 6) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input int k);
    return k >= 5;
  endfunction

  function automatic bit is_mis(input int k, input logic [31:0] a);
    return (a % size_of(k)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input int k, input logic [31:0] a);
    int sz;
    sz = size_of(k);
    if (sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << (a % 4));
    return 4'(3 << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input int k, input logic [31:0] wd);
    int sz;
    sz = size_of(k);
    if (sz == 1) return wd[7:0] * 32'h0101_0101;
    if (sz == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_rdata(input int k, input logic [31:0] a,
                                            input logic [31:0] mem);
    longint v;
    int     sz;
    sz = size_of(k);
    if (sz == 4) return mem;
    v = longint'((mem >> (8 * (a % 4))) & ((32'd1 << (8 * sz)) - 1));
    if ((k == 0 || k == 1) && v >= (64'sd1 << (8 * sz - 1)))
      v = v - (64'sd1 << (8 * sz));
    return 32'(v);
  endfunction

  task automatic set_op(input logic [7:0] m, input logic [31:0] a,
                        input logic [31:0] wd);
    {sw, sh, sb, lhu, lbu, lw, lh, lb} = m;
    load_enb   = |m[4:0];
    address    = a;
    write_data = wd;
  endtask

  task automatic run_op(input logic [7:0] m, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rd,
                        input logic [31:0] mem, input logic berr);
    int gcyc;
    bit got;
    gcyc = -1;
    got  = 0;
    o_done_cyc = -1;
    o_stall_n  = 0;
    o_req_n    = 0;
    o_unstable = 0;
    o_rd  = 'x;
    o_err = 1'bx;
    @(negedge clk);
    set_op(m, a, wd);
    for (int c = 0; c < 40 && !got; c++) begin
      if (c > 0) @(negedge clk);
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      bus.err    = 1'b0;
      bus.rdata  = $urandom;
      #1;
      if (stall) o_stall_n++;
      if (done) begin
        got        = 1;
        o_done_cyc = c;
        o_rd       = read_data;
        o_err      = err;
      end
      if (bus.req) begin
        if (o_req_n == 0) begin
          o_be    = bus.be;
          o_we    = bus.we;
          o_addr  = bus.addr;
          o_wdata = bus.wdata;
        end else if ({bus.be, bus.we, bus.addr, bus.wdata} !==
                     {o_be, o_we, o_addr, o_wdata}) begin
          o_unstable = 1;
        end
        o_req_n++;
        if (o_req_n > gd) begin
          bus.gnt = 1'b1;
          gcyc    = c;
        end
      end
      if (gcyc >= 0 && c == gcyc + rd) begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem;
        bus.err    = berr;
      end
    end
    @(negedge clk);
    set_op(8'h00, $urandom, $urandom);
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.err    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_op(8'h00, 32'h0, 32'h0);
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.err    = 1'b0;
    bus.rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_op(8'h80, 32'h100, 32'h1);
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", read_data); end
    set_op(8'h00, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_basic();
    run_op(8'h80, 32'h100, 32'hDEAD_BEEF, 0, 1, $urandom, 1'b0);
    n_cmp++; if (o_be !== 4'hF) begin n_bad++; $display("FAIL sw_be got %h want f", o_be); end
    n_cmp++; if (o_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata got %h want deadbeef", o_wdata); end
    n_cmp++; if (o_we !== 1'b1) begin n_bad++; $display("FAIL sw_we got %b want 1", o_we); end
    n_cmp++; if (o_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr got %h want 100", o_addr); end
    n_cmp++; if (o_done_cyc != 3) begin n_bad++; $display("FAIL sw_done_cyc got %0d want 3", o_done_cyc); end
    n_cmp++; if (o_stall_n != 3) begin n_bad++; $display("FAIL sw_stall_n got %0d want 3", o_stall_n); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL sw_err got %b want 0", o_err); end
  endtask

  task automatic test_load_ext();
    run_op(8'h01, 32'h103, 32'h0, 0, 1, 32'h80FF_FF7F, 1'b0);
    n_cmp++; if (o_be !== 4'h8) begin n_bad++; $display("FAIL lb_be got %h want 8", o_be); end
    n_cmp++; if (o_rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata got %h want ffffff80", o_rd); end
    n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL lb_we got %b want 0", o_we); end
    run_op(8'h08, 32'h103, 32'h0, 1, 2, 32'h80FF_FF7F, 1'b0);
    n_cmp++; if (o_rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata got %h want 00000080", o_rd); end
    n_cmp++; if (o_done_cyc != 5) begin n_bad++; $display("FAIL lbu_done_cyc got %0d want 5", o_done_cyc); end
  endtask

  task automatic test_half_misaligned();
    run_op(8'h40, 32'h102, 32'h0000_1234, 0, 1, $urandom, 1'b0);
    n_cmp++; if (o_be !== 4'hC) begin n_bad++; $display("FAIL sh_be got %h want c", o_be); end
    n_cmp++; if (o_wdata !== 32'h1234_1234) begin n_bad++; $display("FAIL sh_wdata got %h want 12341234", o_wdata); end
    @(negedge clk);
    set_op(8'h02, 32'h101, 32'h0);
    #1;
    n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL lh_mis got %b want 1", misaligned); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lh_mis_stall got %b want 0", stall); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL lh_mis_req got %b want 0", bus.req); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lh_mis_done got %b want 0", done); end
    set_op(8'h00, 32'h0, 32'h0);
  endtask

  task automatic test_gnt_hold();
    logic [31:0] mem;
    mem = $urandom;
    run_op(8'h04, 32'h104, 32'h0, 5, 0, mem, 1'b0);
    n_cmp++; if (o_req_n != 6) begin n_bad++; $display("FAIL hold_req_n got %0d want 6", o_req_n); end
    n_cmp++; if (o_unstable !== 1'b0) begin n_bad++; $display("FAIL hold_stable got %b want 0", o_unstable); end
    n_cmp++; if (o_done_cyc != 7) begin n_bad++; $display("FAIL hold_done_cyc got %0d want 7", o_done_cyc); end
    n_cmp++; if (o_rd !== mem) begin n_bad++; $display("FAIL hold_rdata got %h want %h", o_rd, mem); end
  endtask

  task automatic test_timeout();
    run_op(8'h04, 32'h108, 32'h0, 1000, 0, $urandom, 1'b0);
    n_cmp++; if (o_done_cyc != TMO + 1) begin n_bad++; $display("FAIL tmo_done_cyc got %0d want %0d", o_done_cyc, TMO + 1); end
    n_cmp++; if (o_req_n != TMO) begin n_bad++; $display("FAIL tmo_req_n got %0d want %0d", o_req_n, TMO); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", o_err); end
    n_cmp++; if (o_rd !== 32'h0) begin n_bad++; $display("FAIL tmo_rdata got %h want 0", o_rd); end
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hCAFE_F00D;
    #1;
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    n_cmp++; if ({done, stall, bus.req} !== 3'b000) begin n_bad++; $display("FAIL tmo_late got %b want 000", {done, stall, bus.req}); end
  endtask

  task automatic test_priority();
    logic [7:0]  ms[4];
    logic [31:0] as[4];
    logic [31:0] mem;
    int          k;
    ms  = '{8'h81, 8'h44, 8'h11, 8'h0A};
    as  = '{32'h10C, 32'h102, 32'h102, 32'h102};
    mem = 32'h8001_0000;
    for (int i = 0; i < 4; i++) begin
      k = first_kind(ms[i]);
      run_op(ms[i], as[i], 32'h5555_AAAA, 0, 1, mem, 1'b0);
      n_cmp++; if (o_be !== exp_be(k, as[i])) begin n_bad++; $display("FAIL prio%0d_be got %h want %h", i, o_be, exp_be(k, as[i])); end
      n_cmp++; if (o_we !== 1'(is_store(k))) begin n_bad++; $display("FAIL prio%0d_we got %b want %b", i, o_we, is_store(k)); end
      if (!is_store(k)) begin
        n_cmp++; if (o_rd !== exp_rdata(k, as[i], mem)) begin n_bad++; $display("FAIL prio%0d_rdata got %h want %h", i, o_rd, exp_rdata(k, as[i], mem)); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] mem;
    @(negedge clk);
    set_op(8'h04, 32'h200, 32'h0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rw_stall0 got %b want 1", stall); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_bad++; $display("FAIL rw_req1 got %b want 1", bus.req); end
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    #1;
    n_cmp++; if ({bus.req, stall} !== 2'b01) begin n_bad++; $display("FAIL rw_wait got %b want 01", {bus.req, stall}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.req, stall, done} !== 3'b000) begin n_bad++; $display("FAIL rw_async got %b want 000", {bus.req, stall, done}); end
    @(negedge clk);
    set_op(8'h00, 32'h0, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1111_2222;
    #1;
    n_cmp++; if ({done, stall} !== 2'b00) begin n_bad++; $display("FAIL rw_stale got %b want 00", {done, stall}); end
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rw_stale_done got %b want 0", done); end
    mem = $urandom;
    run_op(8'h04, 32'h204, 32'h0, 0, 1, mem, 1'b0);
    n_cmp++; if (o_done_cyc != 3) begin n_bad++; $display("FAIL rw_after_cyc got %0d want 3", o_done_cyc); end
    n_cmp++; if (o_rd !== mem) begin n_bad++; $display("FAIL rw_after_rdata got %h want %h", o_rd, mem); end
  endtask

  task automatic test_random();
    int          k, gd, rd, sz;
    logic [31:0] a, wd, mem, erd;
    logic        berr;
    for (int i = 0; i < 60; i++) begin
      k    = $urandom_range(0, 7);
      sz   = size_of(k);
      a    = $urandom;
      wd   = $urandom;
      mem  = $urandom;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      berr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      if (is_mis(k, a)) begin
        @(negedge clk);
        set_op(8'(1 << k), a, wd);
        #1;
        n_cmp++; if ({misaligned, stall, bus.req} !== 3'b100) begin n_bad++; $display("FAIL rnd%0d_mis got %b want 100", i, {misaligned, stall, bus.req}); end
        @(negedge clk);
        #1;
        n_cmp++; if ({bus.req, done, read_data} !== 34'h0) begin n_bad++; $display("FAIL rnd%0d_mis_idle got %b/%b/%h want 0", i, bus.req, done, read_data); end
        set_op(8'h00, 32'h0, 32'h0);
      end else begin
        run_op(8'(1 << k), a, wd, gd, rd, mem, berr);
        n_cmp++; if (o_done_cyc != 2 + gd + rd) begin n_bad++; $display("FAIL rnd%0d_cyc got %0d want %0d", i, o_done_cyc, 2 + gd + rd); end
        n_cmp++; if (o_stall_n != 2 + gd + rd) begin n_bad++; $display("FAIL rnd%0d_stall got %0d want %0d", i, o_stall_n, 2 + gd + rd); end
        n_cmp++; if (o_req_n != gd + 1 || o_unstable) begin n_bad++; $display("FAIL rnd%0d_req got %0d/%b want %0d/0", i, o_req_n, o_unstable, gd + 1); end
        n_cmp++; if (o_be !== exp_be(k, a)) begin n_bad++; $display("FAIL rnd%0d_be got %h want %h", i, o_be, exp_be(k, a)); end
        n_cmp++; if (o_addr !== (a & 32'hFFFF_FFFC)) begin n_bad++; $display("FAIL rnd%0d_addr got %h want %h", i, o_addr, a & 32'hFFFF_FFFC); end
        n_cmp++; if (o_we !== 1'(is_store(k))) begin n_bad++; $display("FAIL rnd%0d_we got %b want %b", i, o_we, is_store(k)); end
        n_cmp++; if (o_err !== berr) begin n_bad++; $display("FAIL rnd%0d_err got %b want %b", i, o_err, berr); end
        if (is_store(k)) begin
          n_cmp++; if (o_wdata !== exp_wdata(k, wd)) begin n_bad++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wdata, exp_wdata(k, wd)); end
        end else begin
          erd = berr ? 32'h0 : exp_rdata(k, a, mem);
          n_cmp++; if (o_rd !== erd) begin n_bad++; $display("FAIL rnd%0d_rdata got %h want %h", i, o_rd, erd); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sw_basic();
    test_load_ext();
    test_half_misaligned();
    test_gnt_hold();
    test_timeout();
    test_priority();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
